// File: rtl/fp_mul_arbiter_if.sv
// Request, multiplier and response bundle of fp_mul_arbiter.
// A requester's operands are accepted at the edge where its req_valid and req_ready are both high.
// A response transfers at the edge where resp_valid and resp_ready are both high.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0]  req_rmode;

    logic [22:0] mul_mantissa_num1;
    logic [22:0] mul_mantissa_num2;
    logic        mul_normilized_bit_num1;
    logic        mul_normilized_bit_num2;
    logic        mul_sign_num1;
    logic        mul_sign_num2;
    logic [7:0]  mul_exp_num1;
    logic [7:0]  mul_exp_num2;
    logic [1:0]  mul_rounding_mode;
    logic [31:0] mul_result;

    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_result;
    logic [ID_W-1:0] resp_id;
    logic            busy;

    modport slave (
        input  req_valid, req_a, req_b, req_rmode, mul_result, resp_ready,
        output req_ready, mul_mantissa_num1, mul_mantissa_num2,
               mul_normilized_bit_num1, mul_normilized_bit_num2,
               mul_sign_num1, mul_sign_num2, mul_exp_num1, mul_exp_num2,
               mul_rounding_mode, resp_valid, resp_result, resp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_rmode, mul_result, resp_ready,
        input  req_ready, mul_mantissa_num1, mul_mantissa_num2,
               mul_normilized_bit_num1, mul_normilized_bit_num2,
               mul_sign_num1, mul_sign_num2, mul_exp_num1, mul_exp_num2,
               mul_rounding_mode, resp_valid, resp_result, resp_id, busy
    );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin scheduler sharing one combinational FP32 multiplier among NUM_REQ requesters.
// One operation in flight; operands are held MUL_LAT cycles before the product is sampled.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_mul_arbiter_if.slave bus,
    output logic [1:0]      o_dbg_state
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

    state_t             r_state, w_next_state;
    logic [ID_W-1:0]    r_rr_ptr, r_id, w_grant, w_ptr_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_grant_found, w_accept, r_zero;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [31:0]        w_a, w_b, r_result;
    logic               r_sign1, r_sign2, r_nb1, r_nb2;
    logic [7:0]         r_exp1, r_exp2;
    logic [22:0]        r_man1, r_man2;
    logic [1:0]         r_rmode, w_rmode;

    // Scan downward so the valid requester closest to r_rr_ptr is the last (winning) assignment.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_grant_found = 1'b1;
                w_grant       = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_a        = bus.req_a[32*int'(w_grant) +: 32];
    assign w_b        = bus.req_b[32*int'(w_grant) +: 32];
    assign w_rmode    = bus.req_rmode[2*int'(w_grant) +: 2];
    assign w_ptr_next = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;
    assign w_accept   = |(bus.req_valid & w_req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)       w_next_state = S_EXEC;
            S_EXEC:  if (r_cnt == '0)    w_next_state = S_RESP;
            S_RESP:  if (bus.resp_ready) w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_grant_found) w_req_ready[w_grant] = 1'b1;
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_id     <= '0;
            r_zero   <= 1'b0;
            r_result <= '0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_nb1    <= 1'b0;
            r_nb2    <= 1'b0;
            r_exp1   <= '0;
            r_exp2   <= '0;
            r_man1   <= '0;
            r_man2   <= '0;
            r_rmode  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign1  <= w_a[31];
                        r_exp1   <= w_a[30:23];
                        r_man1   <= w_a[22:0];
                        r_nb1    <= |w_a[30:23];
                        r_sign2  <= w_b[31];
                        r_exp2   <= w_b[30:23];
                        r_man2   <= w_b[22:0];
                        r_nb2    <= |w_b[30:23];
                        r_rmode  <= w_rmode;
                        r_id     <= w_grant;
                        r_zero   <= (w_a[30:0] == '0) || (w_b[30:0] == '0);
                        r_rr_ptr <= w_ptr_next;
                        r_cnt    <= CNT_W'(MUL_LAT - 1);
                    end
                end
                S_EXEC: begin
                    // Exact-zero operands skip the multiplier; only the sign survives.
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else r_result <= r_zero ? {r_sign1 ^ r_sign2, 31'b0} : bus.mul_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready               = w_req_ready;
    assign bus.busy                    = (r_state != S_IDLE);
    assign bus.resp_valid              = (r_state == S_RESP);
    assign bus.resp_result             = r_result;
    assign bus.resp_id                 = r_id;
    assign bus.mul_sign_num1           = r_sign1;
    assign bus.mul_sign_num2           = r_sign2;
    assign bus.mul_exp_num1            = r_exp1;
    assign bus.mul_exp_num2            = r_exp2;
    assign bus.mul_mantissa_num1       = r_man1;
    assign bus.mul_mantissa_num2       = r_man2;
    assign bus.mul_normilized_bit_num1 = r_nb1;
    assign bus.mul_normilized_bit_num2 = r_nb2;
    assign bus.mul_rounding_mode       = r_rmode;
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Round-robin scheduler that shares one combinational IEEE-754 single-precision multiplier among NUM_REQ requesters.
- Accepts one operation at a time over per-requester valid/ready.
- Unpacks operands onto the multiplier's field-level inputs and waits MUL_LAT cycles for the multiplier path to settle (multicycle constraint).
- Bypasses the multiplier for zero operands, then returns the result with the requester ID over a valid/ready response port.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
ID_W, 2, response ID width, equal to max(1, clog2(NUM_REQ))
MUL_LAT, 2, cycles operands are held stable before the result is sampled (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  32*NUM_REQ  operand A, requester i at [32i+31:32i]
req_b  in  32*NUM_REQ  operand B, same packing
req_rmode  in  2*NUM_REQ  rounding mode: 00 nearest-even, 01 zero, 10 +inf, 11 -inf
mul_mantissa_num1, mul_mantissa_num2  out  23 each  registered mantissas
mul_normilized_bit_num1, mul_normilized_bit_num2  out  1 each  hidden bit
mul_sign_num1, mul_sign_num2  out  1 each  signs
mul_exp_num1, mul_exp_num2  out  8 each  biased exponents
mul_rounding_mode  out  2  registered rounding mode
mul_result  in  32  multiplier result
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_result  out  32  IEEE-754 product
resp_id  out  ID_W  index of the originating requester
busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0, cnt=0.
  - All mul_* operand registers are 0.
  - resp_valid=0, resp_result=0, resp_id=0, busy=0.
  - req_ready=0 while rst_n=0.
  - Reset mid-EXEC/RESP discards the operation. No response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = one-hot(g), combinational. req_ready=0 if no valid or state is not IDLE.
  - On req_valid[g] & req_ready[g] at an edge, register:
    - sign = bit31, exp = bits30:23, mantissa = bits22:0 of a and b.
    - normalised bit = |exp for each operand.
    - rmode and id=g.
  - Also set zero_flag = (a[30:0]==0) | (b[30:0]==0), rr_ptr = (g+1) mod NUM_REQ, cnt = MUL_LAT-1, and go to EXEC.
  - rr_ptr changes only on an accepted request.
- EXEC:
  - mul_* outputs are held stable.
  - If cnt != 0, cnt decrements.
  - If cnt == 0: resp_result = zero_flag ? {a_sign^b_sign, 31'b0} : mul_result. Set resp_valid=1 and go to RESP.
- RESP:
  - resp_valid, resp_result and resp_id are held until resp_valid & resp_ready.
  - On that edge, resp_valid=0 and state goes to IDLE.
  - resp_ready is ignored outside RESP.
- Latency: accept at edge E; resp_valid is high from edge E+MUL_LAT.
- Throughput: at most one operation per MUL_LAT+2 cycles. The mandatory IDLE cycle is not optimised away.
- A requester may drop req_valid while not granted. The request is simply not considered. Data is sampled only at accept.
- NUM_REQ=1: arbiter degenerates to pass-through; rr_ptr stays 0; resp_id=0.
- rr_ptr wraps from NUM_REQ-1 to 0.
- No buffering: exactly one operation in flight. Other requesters stall on req_ready=0.
- Inf/NaN/denormal results are whatever mul_result yields. Only exact-zero operands are bypassed.

Test Plan:
- Single op, requester 0: a=0x3FC00000 (1.5), b=0x40000000 (2.0), rmode=00, resp_ready=1 -> resp_result=0x40400000, resp_id=0, resp_valid first high MUL_LAT cycles after accept, high for exactly 1 cycle.
- All 4 req_valid held high with distinct operands from reset -> grant order 0,1,2,3,0. Each resp_id matches. req_ready never has more than one bit set.
- Zero bypass: a=0x80000000, b=0x40400000 -> resp_result=0x80000000 regardless of mul_result. Also a=0x00000000, b=0xC0000000 -> 0x80000000.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_result/resp_id stable, req_ready=0 throughout, busy=1. Release -> back to IDLE next cycle.
- Rounding-mode routing: requester 2 sends rmode=01 -> mul_rounding_mode=01 for every EXEC cycle, while other requesters' rmode values are ignored.
- Reset mid-EXEC: drive rst_n=0 one cycle after accept -> no resp_valid, rr_ptr=0. Next request from requester 3 is accepted with resp_id=3.
